lc3_bus_arbiter: RTL

//  Parametrised successor to the LC-3 datapath gate mux. N_SRC sources request the shared bus.
//  A registered round-robin arbiter issues a one-hot grant and drives the granted data onto bus_out.
//  A hold limit prevents any one source from starving the others.

---
 rtl/lc3_bus_pkg.sv | 31 +++
 rtl/lc3_bus_rr_pick.sv | 34 +++
 rtl/lc3_bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lc3_bus_pkg.sv
// Shared types and constants for the LC-3 shared-bus arbiter.
// Consumed by lc3_bus_rr_pick and lc3_bus_arbiter via import lc3_bus_pkg::*.
package lc3_bus_pkg;

  // Arbiter FSM: bus free, or owned by exactly one source.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Default configuration of the arbiter.
  localparam int DEF_N_SRC    = 4;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_CNT_W    = 8;

  // Widest grant vector onehot_to_idx can decode; N_SRC must not exceed it.
  localparam int MAX_SRC = 32;

  // Index of the set bit of a one-hot vector (0 for an all-zero vector).
  // OR-ing the indices avoids a priority chain; valid only for one-hot input.
  function automatic int onehot_to_idx(input logic [MAX_SRC-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/lc3_bus_rr_pick.sv
// Combinational round-robin priority encoder.
// Returns the first eligible (req & mask) source scanning ptr+1, ptr+2, ... mod N_SRC,
// so the source at ptr itself is considered last.
module lc3_bus_rr_pick
  import lc3_bus_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [N_SRC-1:0] mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             found_o
);

  logic [N_SRC-1:0] eligible;

  assign eligible = req_i & mask_i;

  // Rotating scan starting just after the pointer; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner_o = '0;
    found_o  = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!found_o && eligible[(int'(ptr_i) + k) % N_SRC]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'((int'(ptr_i) + k) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// LC-3 shared-bus arbiter: registered round-robin one-hot grant with a hold limit,
// plus the grant-driven bus output mux.
// Optional stall statistics counter enabled by defining LC3_BUS_STATS_EN.
module lc3_bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int N_SRC    = DEF_N_SRC,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
`ifdef LC3_BUS_STATS_EN
  , parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] data_in,
  output logic [N_SRC-1:0]       grant,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid
`ifdef LC3_BUS_STATS_EN
  , input  logic                 stats_clr,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  localparam int IDX_W  = $clog2(N_SRC);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [N_SRC-1:0]  ONE_HOT0  = N_SRC'(1);

  arb_state_t        state_q;
  logic [N_SRC-1:0]  grant_q;
  logic [HOLD_W-1:0] hold_q;
  logic [IDX_W-1:0]  ptr_q;

  logic [N_SRC-1:0]  pick_mask;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [N_SRC-1:0]  win_onehot;
  logic              owner_req;
  logic [WIDTH-1:0]  bus_mux;

  // While a source owns the bus only the other sources compete for the next slot.
  assign pick_mask  = (state_q == GRANT) ? ~grant_q : {N_SRC{1'b1}};
  assign win_onehot = ONE_HOT0 << pick_idx;
  assign owner_req  = |(req & grant_q);

  lc3_bus_rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (req),
    .mask_i   (pick_mask),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .found_o  (pick_found)
  );

  // Arbitration FSM: grant, hold counter and round-robin pointer all update together.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      ptr_q   <= IDX_W'(N_SRC - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            grant_q <= win_onehot;
            ptr_q   <= pick_idx;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (owner_req) begin
            if (hold_q < HOLD_LAST) begin
              hold_q <= hold_q + HOLD_W'(1);
            end else begin
              // Hold limit reached: rotate if anyone else waits, otherwise restart the window.
              hold_q <= '0;
              if (pick_found) begin
                grant_q <= win_onehot;
                ptr_q   <= pick_idx;
              end
            end
          end else begin
            // Owner released: hand over directly, or go idle if nobody else wants the bus.
            hold_q <= '0;
            if (pick_found) begin
              grant_q <= win_onehot;
              ptr_q   <= pick_idx;
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // AND-OR select from the registered grant: stable select lines, zero when idle.
  always_comb begin
    bus_mux = '0;
    for (int i = 0; i < N_SRC; i++) begin
      bus_mux = bus_mux | (data_in[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
    end
  end

  assign grant     = grant_q;
  assign bus_out   = bus_mux;
  assign bus_valid = |grant_q;

`ifdef LC3_BUS_STATS_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of cycles in which some requester is not being served.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_q <= '0;
    end else if (stats_clr) begin
      stall_q <= '0;
    end else if ((|(req & ~grant_q)) && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

  // Grant is never shared between sources.
  a_grant_onehot0 : assert property (@(posedge Clk) $onehot0(grant_q));

  // The pointer always names the current owner while the bus is granted.
  a_ptr_is_owner : assert property (@(posedge Clk) disable iff (Reset)
    (state_q == GRANT) |-> (ptr_q == IDX_W'(onehot_to_idx(MAX_SRC'(grant_q)))));

endmodule
